// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: forwarding, load-use stalls,
// branch flushes, memory-wait freezes, timeout flag and event counters.
module hazard_ctrl #(
   parameter int RA_W        = 5,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [RA_W-1:0]  Rs1_D,
   input  logic [RA_W-1:0]  Rs2_D,
   input  logic [RA_W-1:0]  Rs1_E,
   input  logic [RA_W-1:0]  Rs2_E,
   input  logic [RA_W-1:0]  RD_E,
   input  logic             ResultSrcE,
   input  logic             PCSrcE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic [RA_W-1:0]  RD_M,
   input  logic [RA_W-1:0]  RD_W,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic             MemTimeout,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ERR
   } memState_t;

   memState_t       state;
   logic [WC_W-1:0] waitCnt;
   logic            timeoutHit;
   logic            memStall;
   logic            loadUse;

   function automatic logic [1:0] fwdSel(
      input logic [RA_W-1:0] rs
   );
      if (RegWriteM && RD_M != '0 && RD_M == rs)
         return 2'b10;
      else if (RegWriteW && RD_W != '0 && RD_W == rs)
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign timeoutHit = (state == WAIT) && !MemReadyM
                     && (waitCnt == WC_W'(MEM_TIMEOUT - 1));

   assign memStall = ((state == IDLE) && MemReqM && !MemReadyM)
                   || ((state == WAIT) && !MemReadyM && !timeoutHit);

   assign loadUse = ResultSrcE && (RD_E != '0)
                  && (RD_E == Rs1_D || RD_E == Rs2_D);

   // Everything is held low while reset is asserted, even mid-wait.
   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushW    = 1'b0;
      if (rst) begin
         ForwardAE = fwdSel(Rs1_E);
         ForwardBE = fwdSel(Rs2_E);
         priority case (1'b1)
            memStall: begin
               StallF = 1'b1;
               StallD = 1'b1;
               StallE = 1'b1;
               StallM = 1'b1;
               FlushW = 1'b1;
            end
            PCSrcE: begin
               FlushD = 1'b1;
               FlushE = 1'b1;
            end
            loadUse: begin
               StallF = 1'b1;
               StallD = 1'b1;
               FlushE = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         waitCnt    <= '0;
         MemTimeout <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (MemReqM && !MemReadyM) begin
                  state   <= WAIT;
                  waitCnt <= WC_W'(1);
               end
            end
            WAIT: begin
               if (MemReadyM) begin
                  state <= IDLE;
               end else if (timeoutHit) begin
                  state      <= ERR;
                  MemTimeout <= 1'b1;
               end else begin
                  waitCnt <= waitCnt + WC_W'(1);
               end
            end
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         StallCount <= '0;
         FlushCount <= '0;
      end else begin
         if (StallF && StallCount != '1)
            StallCount <= StallCount + CNT_W'(1);
         if (FlushE && FlushCount != '1)
            FlushCount <= FlushCount + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MEM_TIMEOUT = 4 and CNT_W = 2.
// Inputs change just after negedge; outputs are sampled 2 ns later.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
   logic       ResultSrcE, PCSrcE, RegWriteM, RegWriteW;
   logic       MemReqM, MemReadyM;
   logic [1:0] ForwardAE, ForwardBE;
   logic       StallF, StallD, StallE, StallM;
   logic       FlushD, FlushE, FlushW, MemTimeout;
   logic [1:0] StallCount, FlushCount;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(
      .RA_W(5),
      .MEM_TIMEOUT(4),
      .CNT_W(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .Rs1_D(Rs1_D),
      .Rs2_D(Rs2_D),
      .Rs1_E(Rs1_E),
      .Rs2_E(Rs2_E),
      .RD_E(RD_E),
      .ResultSrcE(ResultSrcE),
      .PCSrcE(PCSrcE),
      .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW),
      .RD_M(RD_M),
      .RD_W(RD_W),
      .MemReqM(MemReqM),
      .MemReadyM(MemReadyM),
      .ForwardAE(ForwardAE),
      .ForwardBE(ForwardBE),
      .StallF(StallF),
      .StallD(StallD),
      .StallE(StallE),
      .StallM(StallM),
      .FlushD(FlushD),
      .FlushE(FlushE),
      .FlushW(FlushW),
      .MemTimeout(MemTimeout),
      .StallCount(StallCount),
      .FlushCount(FlushCount)
   );

   task automatic chk(input string tag,
                      input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   // Packed view of the control outputs: {F,D,E,M stalls, D,E,W flushes}
   function automatic logic [15:0] ctl();
      return {9'd0, StallF, StallD, StallE, StallM,
              FlushD, FlushE, FlushW};
   endfunction

   localparam logic [15:0] C_NONE = 16'h00;
   localparam logic [15:0] C_MEM  = 16'h79;
   localparam logic [15:0] C_LU   = 16'h62;
   localparam logic [15:0] C_BR   = 16'h06;

   task automatic clr();
      {Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W} = '0;
      {ResultSrcE, PCSrcE, RegWriteM, RegWriteW} = '0;
      {MemReqM, MemReadyM} = '0;
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic doReset();
      cyc();
      rst = 1'b0;
      #1;
      rst = 1'b1;
   endtask

   task automatic setLu();
      ResultSrcE = 1'b1;
      RD_E       = 5'd3;
      Rs2_D      = 5'd3;
   endtask

   initial begin
      rst = 1'b0;
      clr();
      #2;
      chk("rst_ctl", ctl(), C_NONE);
      chk("rst_scnt", 16'(StallCount), 16'd0);
      chk("rst_fcnt", 16'(FlushCount), 16'd0);
      chk("rst_to", 16'(MemTimeout), 16'd0);
      cyc();
      rst = 1'b1;

      // forwarding
      RegWriteM = 1'b1; RD_M = 5'd5;
      RegWriteW = 1'b1; RD_W = 5'd5;
      Rs1_E = 5'd5; Rs2_E = 5'd5;
      #2;
      chk("fwdA_m_wins", 16'(ForwardAE), 16'h2);
      chk("fwdB_m_wins", 16'(ForwardBE), 16'h2);
      cyc();
      RD_M = 5'd0; RD_W = 5'd0; Rs1_E = 5'd0; Rs2_E = 5'd0;
      #2;
      chk("fwdA_x0", 16'(ForwardAE), 16'h0);
      chk("fwdB_x0", 16'(ForwardBE), 16'h0);
      cyc();
      RD_M = 5'd7; RD_W = 5'd5; Rs1_E = 5'd5; Rs2_E = 5'd7;
      #2;
      chk("fwdA_w", 16'(ForwardAE), 16'h1);
      chk("fwdB_m", 16'(ForwardBE), 16'h2);
      cyc();
      RegWriteM = 1'b0; RD_M = 5'd5;
      #2;
      chk("fwdA_m_nowr", 16'(ForwardAE), 16'h1);
      chk("fwdB_none", 16'(ForwardBE), 16'h0);
      chk("fwd_ctl", ctl(), C_NONE);
      cyc();
      clr();

      // load-use, then the same case under a taken branch
      setLu();
      #2;
      chk("lu_ctl", ctl(), C_LU);
      cyc();
      clr();
      #2;
      chk("lu_ctl_after", ctl(), C_NONE);
      chk("lu_scnt", 16'(StallCount), 16'd1);
      chk("lu_fcnt", 16'(FlushCount), 16'd1);
      setLu();
      PCSrcE = 1'b1;
      #2;
      chk("br_over_lu", ctl(), C_BR);
      cyc();
      clr();
      ResultSrcE = 1'b1;
      #2;
      chk("lu_x0", ctl(), C_NONE);
      chk("br_scnt", 16'(StallCount), 16'd1);
      chk("br_fcnt", 16'(FlushCount), 16'd2);
      cyc();
      clr();

      // memory wait of three cycles
      doReset();
      chk("mw_rst_scnt", 16'(StallCount), 16'd0);
      MemReqM = 1'b1;
      MemReadyM = 1'b1;
      #2;
      chk("mem_1cyc", ctl(), C_NONE);
      cyc();
      MemReadyM = 1'b0;
      #2;
      chk("mw_c1", ctl(), C_MEM);
      cyc();
      setLu();
      PCSrcE = 1'b1;
      #2;
      chk("mw_c2_prio", ctl(), C_MEM);
      cyc();
      {ResultSrcE, PCSrcE, RD_E, Rs2_D} = '0;
      #2;
      chk("mw_c3", ctl(), C_MEM);
      cyc();
      MemReadyM = 1'b1;
      #2;
      chk("mw_ready", ctl(), C_NONE);
      cyc();
      clr();
      #2;
      chk("mw_idle", ctl(), C_NONE);
      chk("mw_to", 16'(MemTimeout), 16'd0);
      chk("mw_scnt", 16'(StallCount), 16'd3);
      chk("mw_fcnt", 16'(FlushCount), 16'd0);

      // timeout with MEM_TIMEOUT = 4
      doReset();
      MemReqM = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         #2;
         chk($sformatf("to_stall%0d", i), ctl(), C_MEM);
         cyc();
      end
      #2;
      chk("to_hit_ctl", ctl(), C_NONE);
      chk("to_hit_flag", 16'(MemTimeout), 16'd0);
      cyc();
      #2;
      chk("to_err_ctl", ctl(), C_NONE);
      chk("to_err_flag", 16'(MemTimeout), 16'd1);
      cyc();
      #2;
      chk("to_retry", ctl(), C_MEM);
      cyc();
      MemReadyM = 1'b1;
      #2;
      chk("to_retry_ok", ctl(), C_NONE);
      cyc();
      clr();
      #2;
      chk("to_sticky", 16'(MemTimeout), 16'd1);
      chk("to_scnt_sat", 16'(StallCount), 16'd3);

      // asynchronous reset in the second wait cycle
      cyc();
      MemReqM = 1'b1;
      RegWriteM = 1'b1; RD_M = 5'd9; Rs1_E = 5'd9;
      #2;
      chk("rw_c1", ctl(), C_MEM);
      cyc();
      #2;
      chk("rw_c2", ctl(), C_MEM);
      #1;
      rst = 1'b0;
      #1;
      chk("rw_ctl", ctl(), C_NONE);
      chk("rw_fwd", 16'(ForwardAE), 16'h0);
      chk("rw_scnt", 16'(StallCount), 16'd0);
      chk("rw_fcnt", 16'(FlushCount), 16'd0);
      chk("rw_to", 16'(MemTimeout), 16'd0);
      cyc();
      clr();
      rst = 1'b1;
      #2;
      chk("rw_idle", ctl(), C_NONE);

      // counter saturation
      doReset();
      setLu();
      for (int i = 1; i <= 5; i++) begin
         cyc();
         #2;
         chk($sformatf("sat_s%0d", i), 16'(StallCount),
             16'(i > 3 ? 3 : i));
      end
      chk("sat_fcnt", 16'(FlushCount), 16'd3);
      cyc();
      clr();

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard controller for the 5-stage pipeline; a successor to the forwarding-only hazard unit. It generates the EX-stage operand forwarding selects, load-use stalls, taken-branch flushes, and whole-pipeline freezes while a variable-latency data memory completes. It also keeps a sticky memory-timeout flag and saturating stall/flush event counters. It sits beside the pipeline top and drives the stall/flush enables of every pipeline register.

## Interface
Parameters:
- RA_W, 5, register address width (rd == 0 is the hard-wired zero register)
- MEM_TIMEOUT, 16, maximum wait cycles for MemReadyM before timeout (≥ 2)
- CNT_W, 16, width of the event counters

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- Rs1_D, Rs2_D  in  RA_W  source registers in Decode
- Rs1_E, Rs2_E, RD_E  in  RA_W  sources/destination in Execute
- ResultSrcE  in  1  Execute instruction is a load
- PCSrcE  in  1  taken branch/jump resolved in Execute
- RegWriteM, RegWriteW  in  1  register-write enables, Memory/Writeback
- RD_M, RD_W  in  RA_W  destinations, Memory/Writeback
- MemReqM  in  1  Memory-stage instruction accesses data memory
- MemReadyM  in  1  data memory completes this cycle
- ForwardAE, ForwardBE  out  2  00 = regfile, 10 = ALU_ResultM, 01 = ResultW
- StallF, StallD, StallE, StallM  out  1  hold the PC / stage register
- FlushD, FlushE, FlushW  out  1  load a bubble into the stage register
- MemTimeout  out  1  sticky, memory timed out
- StallCount, FlushCount  out  CNT_W  saturating event counters

## Operation
- Forwarding, per operand X ∈ {1,2}:
  - 10 if RegWriteM && RD_M != 0 && RD_M == RsX_E.
  - Otherwise 01 if RegWriteW && RD_W != 0 && RD_W == RsX_E.
  - Otherwise 00. M has priority over W.
- mem_stall = (state == IDLE && MemReqM && !MemReadyM) || (state == WAIT && !MemReadyM && !timeout_hit).
- lu = ResultSrcE && RD_E != 0 && (RD_E == Rs1_D || RD_E == Rs2_D).
- Priority is mem_stall > PCSrcE > lu:
  - mem_stall: StallF = StallD = StallE = StallM = 1, FlushW = 1, FlushD = FlushE = 0. The branch redirect is deferred because E is frozen and PCSrcE stays held.
  - PCSrcE: FlushD = FlushE = 1, all stalls 0, and lu is ignored.
  - lu: StallF = StallD = 1, FlushE = 1.
  - None of the above: all 0.
- Memory FSM states IDLE, WAIT, ERR:
  - IDLE -> WAIT when MemReqM && !MemReadyM; the wait counter is loaded with 1.
  - WAIT -> IDLE when MemReadyM.
  - WAIT: timeout_hit when the counter == MEM_TIMEOUT − 1 and !MemReadyM. This forces WAIT -> ERR and sets MemTimeout.
  - ERR -> IDLE unconditionally after 1 cycle. No stall is asserted in ERR; the access retires with whatever data is present.
  - MemTimeout clears only on reset.
- StallCount += 1 on every cycle with StallF = 1. FlushCount += 1 on every cycle with FlushE = 1. Both saturate at 2^CNT_W − 1.

## Timing
- All stall, flush and forward outputs are combinational from the inputs and the registered state; there is no added latency.
- State, the wait counter, MemTimeout and the event counters update on posedge clk.
- Reset (rst = 0, asynchronous):
  - state = IDLE, wait counter = 0, MemTimeout = 0, counters = 0.
  - While rst = 0, all stall/flush outputs are forced to 0 and ForwardAE = ForwardBE = 00.
- A single-cycle memory (MemReadyM = 1 in the same cycle as MemReqM) causes no stall.
- Wait length: N cycles of !MemReadyM give N stall cycles, up to MEM_TIMEOUT − 1.
- Reset during WAIT immediately drops the stalls and returns to IDLE.
- Counter saturation: at all-ones the counter holds its value; it does not wrap.

## Test plan
- Forwarding: RegWriteM = 1, RD_M = 5, RegWriteW = 1, RD_W = 5, Rs1_E = 5 -> ForwardAE = 10 (M wins). With RD_M = 0 and RD_W = 0 -> 00.
- Load-use: ResultSrcE = 1, RD_E = 3, Rs2_D = 3 -> StallF = StallD = FlushE = 1 for 1 cycle, StallCount = 1. The same case with PCSrcE = 1 -> FlushD = FlushE = 1, StallF = 0.
- Memory wait: MemReqM held, MemReadyM low 3 cycles then high -> StallF/D/E/M = 1 and FlushW = 1 for exactly 3 cycles, state returns to IDLE, MemTimeout = 0.
- Timeout: MEM_TIMEOUT = 4, MemReadyM never asserted -> stall for 3 cycles, then MemTimeout = 1 and the stalls drop. MemTimeout stays 1 through later accesses until rst = 0.
- Reset mid-WAIT: assert rst = 0 asynchronously in the 2nd wait cycle -> all outputs 0 before the next clock edge, counters 0.
- Saturation: CNT_W = 2, 5 load-use cycles -> StallCount = 3.
